// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- sequential ALU with single-cycle logic/arithmetic ops and
// iterative (one bit per cycle) unsigned multiply and restoring divide.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst_n        : asynchronous active-low reset
//   start        : begin an operation (only looked at in IDLE)
//   OP1, OP2     : operands, latched when start is accepted
//   ALU_Control  : opcode, latched when start is accepted
//   Salida       : result low word (registered)
//   Salida_Hi    : product high word / remainder, 0 for other ops (registered)
//   ZF           : Salida of the last completed op is all zeros
//   div_by_zero  : last completed op was DIVU with OP2 = 0
//   busy         : FSM is in CALC or FIN
//   done         : one-cycle pulse (FIN state) marking fresh results
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH    = 32,
  parameter int OPCODE_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [WIDTH-1:0]    OP1,
  input  logic [WIDTH-1:0]    OP2,
  input  logic [OPCODE_W-1:0] ALU_Control,
  output logic [WIDTH-1:0]    Salida,
  output logic [WIDTH-1:0]    Salida_Hi,
  output logic                ZF,
  output logic                div_by_zero,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(4'b0000);
  localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(4'b0001);
  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(4'b0010);
  localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(4'b0110);
  localparam logic [OPCODE_W-1:0] OP_SLTU  = OPCODE_W'(4'b0111);
  localparam logic [OPCODE_W-1:0] OP_SLT   = OPCODE_W'(4'b1000);
  localparam logic [OPCODE_W-1:0] OP_NOR   = OPCODE_W'(4'b1100);
  localparam logic [OPCODE_W-1:0] OP_MULTU = OPCODE_W'(4'b1101);
  localparam logic [OPCODE_W-1:0] OP_DIVU  = OPCODE_W'(4'b1110);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hi;      // partial product high / running remainder
  logic [WIDTH-1:0] r_lo;      // multiplier -> product low / dividend -> quotient
  logic [WIDTH-1:0] r_opa;     // multiplicand or divisor
  logic             r_is_div;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_salida;
  logic [WIDTH-1:0] r_salida_hi;
  logic             r_zf;
  logic             r_dbz;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_quick_lo;
  logic [WIDTH-1:0] w_quick_hi;
  logic             w_quick_dbz;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_start_iter;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_nxt_hi;
  logic [WIDTH-1:0] w_nxt_lo;

  assign w_is_mul     = (ALU_Control == OP_MULTU);
  assign w_is_div     = (ALU_Control == OP_DIVU);
  // Divide-by-zero is resolved immediately instead of iterating.
  assign w_start_iter = w_is_mul || (w_is_div && (OP2 != '0));

  // Single-cycle results computed straight from the live inputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_quick_lo  = '0;
    w_quick_hi  = '0;
    w_quick_dbz = 1'b0;
    case (ALU_Control)
      OP_ADD:  w_quick_lo = OP1 + OP2;
      OP_SUB:  w_quick_lo = OP1 - OP2;
      OP_AND:  w_quick_lo = OP1 & OP2;
      OP_OR:   w_quick_lo = OP1 | OP2;
      OP_NOR:  w_quick_lo = ~(OP1 | OP2);
      OP_SLTU: w_quick_lo = {{(WIDTH-1){1'b0}}, (OP1 < OP2)};
      OP_SLT:  w_quick_lo = {{(WIDTH-1){1'b0}}, ($signed(OP1) < $signed(OP2))};
      OP_DIVU: begin
        w_quick_lo  = '1;
        w_quick_hi  = OP1;
        w_quick_dbz = 1'b1;
      end
      default: begin
        w_quick_lo = '0;
      end
    endcase
  end

  // Shift-add multiply step: conditionally add the multiplicand to the high
  // half, then shift the whole {carry, hi, lo} right by one.
  assign w_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opa} : '0);

  // Restoring divide step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. The shifted remainder needs WIDTH+1 bits
  // for the compare, but a successful difference always fits in WIDTH bits.
  assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_opa});
  assign w_diff   = w_rem_sh[WIDTH-1:0] - r_opa;

  always_comb begin
    w_nxt_hi = w_add[WIDTH:1];
    w_nxt_lo = {w_add[0], r_lo[WIDTH-1:1]};
    if (r_is_div) begin
      w_nxt_hi = w_ge ? w_diff : w_rem_sh[WIDTH-1:0];
      w_nxt_lo = {r_lo[WIDTH-2:0], w_ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opa       <= '0;
      r_is_div    <= 1'b0;
      r_cnt       <= '0;
      r_salida    <= '0;
      r_salida_hi <= '0;
      r_zf        <= 1'b0;
      r_dbz       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // sees the pre-edge values of the others, independent of statement order.
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (w_start_iter) begin
              r_hi     <= '0;
              r_lo     <= w_is_div ? OP1 : OP2;
              r_opa    <= w_is_div ? OP2 : OP1;
              r_is_div <= w_is_div;
              r_cnt    <= '0;
              r_state  <= S_CALC;
            end else begin
              r_salida    <= w_quick_lo;
              r_salida_hi <= w_quick_hi;
              r_zf        <= (w_quick_lo == '0);
              r_dbz       <= w_quick_dbz;
              r_done      <= 1'b1;
              r_state     <= S_FIN;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_nxt_hi;
          r_lo  <= w_nxt_lo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_cnt       <= '0;
            r_salida    <= w_nxt_lo;
            r_salida_hi <= w_nxt_hi;
            r_zf        <= (w_nxt_lo == '0);
            r_dbz       <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_FIN;
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Salida      = r_salida;
  assign Salida_Hi   = r_salida_hi;
  assign ZF          = r_zf;
  assign div_by_zero = r_dbz;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH = 32). Expected results
// come from a plain-arithmetic reference model; latency, busy length, done
// pulse width, result hold, reset abort and start-while-busy are also checked.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int W = 32;

  localparam logic [3:0] C_AND   = 4'b0000;
  localparam logic [3:0] C_OR    = 4'b0001;
  localparam logic [3:0] C_ADD   = 4'b0010;
  localparam logic [3:0] C_SUB   = 4'b0110;
  localparam logic [3:0] C_SLTU  = 4'b0111;
  localparam logic [3:0] C_SLT   = 4'b1000;
  localparam logic [3:0] C_NOR   = 4'b1100;
  localparam logic [3:0] C_MULTU = 4'b1101;
  localparam logic [3:0] C_DIVU  = 4'b1110;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [3:0]   ctl;
  logic [W-1:0] salida;
  logic [W-1:0] salida_hi;
  logic         zf;
  logic         dbz;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(W), .OPCODE_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .OP1         (op1),
    .OP2         (op2),
    .ALU_Control (ctl),
    .Salida      (salida),
    .Salida_Hi   (salida_hi),
    .ZF          (zf),
    .div_by_zero (dbz),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: results straight from the operation definitions.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] lo, output logic [W-1:0] hi,
                       output logic e_dbz, output int lat);
    logic [2*W-1:0] prod;
    lo = '0; hi = '0; e_dbz = 1'b0; lat = 1;
    case (op)
      C_ADD:  lo = a + b;
      C_SUB:  lo = a - b;
      C_AND:  lo = a & b;
      C_OR:   lo = a | b;
      C_NOR:  lo = ~(a | b);
      C_SLTU: lo = (a < b) ? 32'd1 : 32'd0;
      C_SLT:  lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      C_MULTU: begin
        prod = 64'(a) * 64'(b);
        lo   = prod[W-1:0];
        hi   = prod[2*W-1:W];
        lat  = W + 1;
      end
      C_DIVU: begin
        if (b == 0) begin
          lo = '1; hi = a; e_dbz = 1'b1;
        end else begin
          lo = a / b; hi = a % b; lat = W + 1;
        end
      end
      default: lo = '0;
    endcase
  endtask

  // Issue one op from IDLE, scramble inputs while it runs, check everything.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] e_lo, e_hi;
    logic         e_dbz;
    int           e_lat;
    int           n;
    int           n_busy;
    model(op, a, b, e_lo, e_hi, e_dbz, e_lat);
    ctl = op; op1 = a; op2 = b; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    n      = 1;
    n_busy = busy ? 1 : 0;
    while (!done && n < 100) begin
      ctl   = 4'($urandom);
      op1   = $urandom;
      op2   = $urandom;
      start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
      if (busy) n_busy++;
    end
    start = 1'b0;
    check($sformatf("latency op=%h", op), 64'(n), 64'(e_lat));
    check($sformatf("busy_cycles op=%h", op), 64'(n_busy), 64'(e_lat));
    check($sformatf("Salida op=%h a=%h b=%h", op, a, b), 64'(salida), 64'(e_lo));
    check($sformatf("Salida_Hi op=%h a=%h b=%h", op, a, b), 64'(salida_hi), 64'(e_hi));
    check($sformatf("ZF op=%h", op), 64'(zf), 64'(e_lo == 0));
    check($sformatf("div_by_zero op=%h", op), 64'(dbz), 64'(e_dbz));
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'(0));
    check("busy_back_idle", 64'(busy), 64'(0));
    check("Salida_hold", 64'(salida), 64'(e_lo));
  endtask

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] edge_vals [4];
    edge_vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000};
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return W'($urandom_range(0, 15));
      default: return edge_vals[$urandom_range(0, 3)];
    endcase
  endfunction

  initial begin
    logic [3:0]   op_tab [9];
    logic [3:0]   r_op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           n_done;
    int           first;
    int           second;

    op_tab = '{C_ADD, C_SUB, C_AND, C_OR, C_SLTU, C_SLT, C_NOR, C_MULTU, C_DIVU};

    // Reset state
    rst_n = 1'b0; start = 1'b0; op1 = '0; op2 = '0; ctl = '0;
    #12;
    check("rst Salida", 64'(salida), 64'(0));
    check("rst Salida_Hi", 64'(salida_hi), 64'(0));
    check("rst ZF", 64'(zf), 64'(0));
    check("rst div_by_zero", 64'(dbz), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    run_op(C_ADD,   32'hFFFF_FFFF, 32'h1);
    check("ADD wrap ZF", 64'(zf), 64'(1));
    run_op(C_SLT,   32'hFFFF_FFFF, 32'h1);
    check("SLT signed", 64'(salida), 64'(1));
    run_op(C_SLTU,  32'hFFFF_FFFF, 32'h1);
    check("SLTU unsigned", 64'(salida), 64'(0));
    run_op(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("MULTU max hi", 64'(salida_hi), 64'h0000_0000_FFFF_FFFE);
    run_op(C_DIVU,  32'd100, 32'd7);
    check("DIVU 100/7 q", 64'(salida), 64'(14));
    run_op(C_DIVU,  32'd5, 32'd0);
    check("DIVU by zero flag", 64'(dbz), 64'(1));
    run_op(C_AND,   32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("dbz cleared", 64'(dbz), 64'(0));
    run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
    run_op(C_MULTU, 32'h0, 32'h1234_5678);
    run_op(C_DIVU,  32'h3, 32'hFFFF_FFFF);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      r_op = (i % 8 == 7) ? 4'($urandom) : op_tab[$urandom_range(0, 8)];
      a    = rand_operand();
      b    = rand_operand();
      run_op(r_op, a, b);
    end

    // Reset in the middle of a multiply aborts it
    run_op(C_ADD, 32'h10, 32'h20);
    ctl = C_MULTU; op1 = 32'd1234; op2 = 32'd5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort Salida", 64'(salida), 64'(0));
    check("abort Salida_Hi", 64'(salida_hi), 64'(0));
    check("abort busy", 64'(busy), 64'(0));
    check("abort done", 64'(done), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("abort no_done", 64'(n_done), 64'(0));
    run_op(C_ADD, 32'd2, 32'd3);
    check("post-reset ADD", 64'(salida), 64'(5));

    // start held high with ADD across a multiply
    ctl = C_MULTU; op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1;
    ctl = C_ADD; op1 = 32'd7; op2 = 32'd9;
    n_done = 0; first = -1; second = -1;
    for (int i = 1; i <= 45; i++) begin
      if (done) begin
        n_done++;
        if (first < 0) begin
          first = i;
          check("held MULTU lo", 64'(salida), 64'(1));
          check("held MULTU hi", 64'(salida_hi), 64'h0000_0000_FFFF_FFFE);
        end else if (second < 0) begin
          second = i;
          start  = 1'b0;
          check("held ADD lo", 64'(salida), 64'(16));
          check("held ADD hi", 64'(salida_hi), 64'(0));
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("held done count", 64'(n_done), 64'(2));
    check("held MULTU done cycle", 64'(first), 64'(W + 1));
    check("held ADD done cycle", 64'(second), 64'(W + 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal range 8..64.
REQ-002 Parameter: OPCODE_W, default 4, width of ALU_Control; fixed at 4, not overridable in legal use.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 Port: OP1  input  WIDTH  first operand; latched on accepted start.
REQ-007 Port: OP2  input  WIDTH  second operand; latched on accepted start.
REQ-008 Port: ALU_Control  input  4  operation select; latched on accepted start.
REQ-009 Port: Salida  output  WIDTH  result low word, registered.
REQ-010 Port: Salida_Hi  output  WIDTH  result high word (product high / remainder), registered; 0 for all other ops.
REQ-011 Port: ZF  output  1  registered; 1 when completed Salida is all zeros.
REQ-012 Port: div_by_zero  output  1  registered; 1 when completed DIVU had OP2 = 0.
REQ-013 Port: busy  output  1  high whenever FSM is not IDLE.
REQ-014 Port: done  output  1  one-cycle pulse marking new valid results.

Function
REQ-015 Opcodes: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0111 SLTU (unsigned), 1000 SLT (signed two's complement), 1100 NOR, 1101 MULTU, 1110 DIVU; any other code yields Salida=0, Salida_Hi=0.
REQ-016 ADD/SUB wrap modulo 2^WIDTH; no carry/overflow output.
REQ-017 SLTU/SLT: Salida = 1 if OP1 < OP2 (respective signedness), else 0, zero-extended.
REQ-018 MULTU: unsigned 2*WIDTH product; {Salida_Hi, Salida} = OP1*OP2; iterative shift-add, one bit per cycle.
REQ-019 DIVU: unsigned restoring division, one quotient bit per cycle; Salida = quotient, Salida_Hi = remainder.
REQ-020 DIVU with OP2 = 0: Salida = all ones, Salida_Hi = OP1, div_by_zero = 1, completes in single-cycle latency.
REQ-021 FSM states: IDLE, CALC, FIN. IDLE->CALC on start with MULTU/DIVU (nonzero divisor); IDLE->FIN on start with any other op; CALC->FIN after WIDTH iterations; FIN->IDLE unconditionally.
REQ-022 Latency: single-cycle ops assert done 1 cycle after start edge; MULTU/DIVU assert done WIDTH+1 cycles after start edge.
REQ-023 done is high exactly in FIN; busy is high in CALC and FIN.
REQ-024 Salida, Salida_Hi, ZF, div_by_zero update only on the edge entering FIN and hold until the next completion.
REQ-025 start while busy is ignored; operand/opcode inputs changing during CALC have no effect.
REQ-026 start asserted in the FIN cycle is ignored; earliest accepted back-to-back start is the cycle after done.
REQ-027 ZF evaluates Salida only; Salida_Hi does not affect ZF.
REQ-028 div_by_zero clears to 0 on completion of any operation other than DIVU-by-zero.

Reset
REQ-029 rst_n low asynchronously forces IDLE; Salida=0, Salida_Hi=0, ZF=0, div_by_zero=0, busy=0, done=0.
REQ-030 Reset during CALC aborts the operation; no done pulse is produced for it; internal iteration counter clears to 0.
REQ-031 First accepted start is the first rising edge with rst_n high and start high.

Verification (WIDTH=32)
REQ-032 ADD OP1=0xFFFFFFFF, OP2=1 -> one cycle later done=1, Salida=0, ZF=1.
REQ-033 SLT OP1=0xFFFFFFFF, OP2=1 -> Salida=1; SLTU same operands -> Salida=0, ZF=1.
REQ-034 MULTU OP1=0xFFFFFFFF, OP2=0xFFFFFFFF -> busy 33 cycles, done on cycle 33, Salida_Hi=0xFFFFFFFE, Salida=0x00000001, ZF=0.
REQ-035 DIVU OP1=100, OP2=7 -> done on cycle 33, Salida=14, Salida_Hi=2; DIVU OP1=5, OP2=0 -> done after 1 cycle, Salida=0xFFFFFFFF, Salida_Hi=5, div_by_zero=1.
REQ-036 MULTU started, rst_n pulsed low at cycle 10 -> outputs zero immediately, no done; new ADD 2+3 after reset -> Salida=5 after 1 cycle.
REQ-037 start held high with ADD throughout a MULTU -> exactly one done per accepted op, MULTU result unchanged, ADD accepted the cycle after done.
